imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 142 ++++++++++++++
 tb/tb_imem_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Instruction memory with a streaming program loader. Clears
//                the array to NOP on every (re)load, accepts an image word by
//                word, then releases the core from reset and serves fetches.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader #(
    parameter int          DEPTH    = 256,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    input  logic [31:0] pcF,
    output logic [31:0] instrF,
    output logic        core_rst_n,
    output logic        load_done,
    output logic        load_err
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW-1:0] c_LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        LOAD  = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] r_wptr;
    logic          r_start_pend;
    logic          r_core_rst_n;
    logic          r_load_done;
    logic          r_load_err;

    logic          w_hs;
    logic          w_fin;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [31:0]   w_wdata;
    logic          w_enter_load;
    logic          w_unused_pcf;

    logic [31:0]   mem [DEPTH];

    // State register; reset always restarts the clear sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= CLEAR;
        else        r_state <= w_state_nxt;
    end

    // Next state, handshake and memory write port selection.
    always_comb begin
        w_state_nxt = r_state;
        load_ready  = 1'b0;
        w_hs        = 1'b0;
        w_fin       = 1'b0;
        w_we        = 1'b0;
        w_waddr     = r_cnt;
        w_wdata     = NOP_WORD;
        case (r_state)
            CLEAR: begin
                w_we = 1'b1;
                if (r_cnt == c_LAST_IDX)
                    w_state_nxt = (r_start_pend || load_start) ? LOAD : IDLE;
            end
            IDLE: begin
                if (load_start) w_state_nxt = LOAD;
            end
            LOAD: begin
                load_ready = 1'b1;
                w_hs       = load_valid;
                if (w_hs) begin
                    w_we    = 1'b1;
                    w_waddr = r_wptr;
                    w_wdata = load_data;
                    // Last word, or the array is full: the image is complete.
                    if (load_last || (r_wptr == c_LAST_IDX)) begin
                        w_fin       = 1'b1;
                        w_state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (load_start) w_state_nxt = CLEAR;
            end
            default: w_state_nxt = CLEAR;
        endcase
    end

    assign w_enter_load = (w_state_nxt == LOAD) && (r_state != LOAD);

    // Counters, start latch and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_wptr       <= '0;
            r_start_pend <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_core_rst_n <= (w_state_nxt == RUN);
            r_load_done  <= w_fin;
            r_cnt        <= (r_state == CLEAR) ? r_cnt + 1'b1 : '0;

            if (r_state == CLEAR)
                r_start_pend <= (w_state_nxt == CLEAR) ? (r_start_pend | load_start) : 1'b0;
            else if ((r_state == RUN) && load_start)
                r_start_pend <= 1'b1;

            if (w_enter_load)  r_wptr <= '0;
            else if (w_hs)     r_wptr <= r_wptr + 1'b1;

            if (w_enter_load)              r_load_err <= 1'b0;
            else if (w_fin && !load_last)  r_load_err <= 1'b1;
        end
    end

    // Single write port; the array is initialised by the clear sweep, not reset.
    always_ff @(posedge clk) begin
        if (w_we) mem[w_waddr] <= w_wdata;
    end

    assign instrF       = (r_state == RUN) ? mem[pcF[AW+1:2]] : NOP_WORD;
    assign core_rst_n   = r_core_rst_n;
    assign load_done    = r_load_done;
    assign load_err     = r_load_err;
    assign w_unused_pcf = ^{pcF[31:AW+2], pcF[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader: directed vectors plus a
//                phase-level reference model compared on every falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam int P_CLR = 0, P_IDL = 1, P_LD = 2, P_RN = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic [31:0] pcF = '0;
    logic [31:0] instrF;
    logic        core_rst_n;
    logic        load_done;
    logic        load_err;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // Reference model state: phase, remaining clear cycles, image array.
    int          m_phase;
    int          m_clear_left;
    int          m_wcount;
    bit          m_pend, m_core, m_done, m_err;
    logic [31:0] m_mem [DEPTH];

    logic [31:0] prog [4] = '{32'h00500093, 32'h00300113, 32'h002081B3, 32'h00000013};

    imem_loader #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .pcF        (pcF),
        .instrF     (instrF),
        .core_rst_n (core_rst_n),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Phase-level model: clearing is a countdown that wipes the image at once.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase      <= P_CLR;
            m_clear_left <= DEPTH;
            m_pend       <= 1'b0;
            m_wcount     <= 0;
            m_core       <= 1'b0;
            m_done       <= 1'b0;
            m_err        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= NOP;
        end else begin
            m_done <= 1'b0;
            case (m_phase)
                P_CLR: begin
                    m_clear_left <= m_clear_left - 1;
                    if (load_start) m_pend <= 1'b1;
                    if (m_clear_left == 1) begin
                        m_pend <= 1'b0;
                        if (m_pend || load_start) begin
                            m_phase  <= P_LD;
                            m_wcount <= 0;
                            m_err    <= 1'b0;
                        end else begin
                            m_phase <= P_IDL;
                        end
                    end
                end
                P_IDL: begin
                    if (load_start) begin
                        m_phase  <= P_LD;
                        m_wcount <= 0;
                        m_err    <= 1'b0;
                    end
                end
                P_LD: begin
                    if (load_valid) begin
                        m_mem[m_wcount] <= load_data;
                        m_wcount        <= m_wcount + 1;
                        if (load_last || m_wcount == DEPTH - 1) begin
                            m_phase <= P_RN;
                            m_done  <= 1'b1;
                            m_core  <= 1'b1;
                            if (!load_last) m_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (load_start) begin
                        m_phase      <= P_CLR;
                        m_clear_left <= DEPTH;
                        m_pend       <= 1'b1;
                        m_core       <= 1'b0;
                        for (int i = 0; i < DEPTH; i++) m_mem[i] <= NOP;
                    end
                end
            endcase
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_ready", 32'(load_ready), 32'(m_phase == P_LD));
            check("cmp_core_rst_n", 32'(core_rst_n), 32'(m_core));
            check("cmp_done", 32'(load_done), 32'(m_done));
            check("cmp_err", 32'(load_err), 32'(m_err));
            check("cmp_instr", instrF, (m_phase == P_RN) ? m_mem[pcF[9:2]] : NOP);
        end
    end

    initial begin
        // Reset and release.
        repeat (3) cyc();
        cmp_en = 1'b1;
        check("rst_ready", 32'(load_ready), 32'd0);
        check("rst_core", 32'(core_rst_n), 32'd0);
        check("rst_instr", instrF, NOP);
        rst_n = 1'b1;

        // Clear lasts exactly DEPTH cycles, then idle serves NOP everywhere.
        repeat (DEPTH) cyc();
        for (int a = 0; a < 8; a++) begin
            pcF = 32'(a * 132 + 1);
            #1 check("idle_instr", instrF, 32'h00000013);
        end
        check("idle_core", 32'(core_rst_n), 32'd0);
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        check("idle_start_ready", 32'(load_ready), 32'd1);

        // Four-word image, back to back.
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = (i == 3);
            cyc();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("p4_done", 32'(load_done), 32'd1);
        check("p4_core", 32'(core_rst_n), 32'd1);
        cyc();
        check("p4_done_pulse", 32'(load_done), 32'd0);
        pcF = 32'h8;  #1 check("p4_pc8", instrF, 32'h002081B3);
        pcF = 32'h40; #1 check("p4_pc40", instrF, 32'h00000013);
        pcF = 32'h0;  #1 check("p4_pc0", instrF, 32'h00500093);

        // Reload from RUN, then stream with valid toggling.
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        check("rl_core_low", 32'(core_rst_n), 32'd0);
        repeat (DEPTH - 1) cyc();
        check("rl_still_clear", 32'(load_ready), 32'd0);
        cyc();
        check("rl_direct_load", 32'(load_ready), 32'd1);
        for (int i = 0; i < 7; i++) begin
            load_valid = (i % 2 == 0);
            load_data  = (i % 2 == 0) ? prog[i/2] : 32'hDEADBEEF;
            load_last  = (i == 6) || (i % 2 == 1);
            cyc();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("tg_done", 32'(load_done), 32'd1);
        pcF = 32'h4; #1 check("tg_pc4", instrF, 32'h00300113);
        pcF = 32'hC; #1 check("tg_pcC", instrF, 32'h00000013);

        // Overflow: 257 words without last; start during LOAD is ignored.
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        repeat (DEPTH) cyc();
        for (int i = 0; i < DEPTH + 1; i++) begin
            load_valid = 1'b1;
            load_data  = 32'h10000000 + 32'(i);
            load_start = (i == 5);
            pcF        = 32'(i * 4);
            cyc();
            if (i == DEPTH - 1) begin
                check("ov_done", 32'(load_done), 32'd1);
                check("ov_err", 32'(load_err), 32'd1);
            end
        end
        load_valid = 1'b0;
        load_start = 1'b0;
        check("ov_ready_low", 32'(load_ready), 32'd0);
        pcF = 32'h3FC; #1 check("ov_pc3fc", instrF, 32'h100000FF);
        pcF = 32'h0;   #1 check("ov_pc0", instrF, 32'h10000000);

        // Reload one word: old image must be gone.
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        check("r1_core_low", 32'(core_rst_n), 32'd0);
        repeat (DEPTH) cyc();
        check("r1_ready", 32'(load_ready), 32'd1);
        check("r1_err_clr", 32'(load_err), 32'd0);
        load_valid = 1'b1; load_data = 32'hAAAA0001; load_last = 1'b1;
        cyc();
        load_valid = 1'b0; load_last = 1'b0;
        check("r1_done", 32'(load_done), 32'd1);
        pcF = 32'h4; #1 check("r1_pc4", instrF, 32'h00000013);
        pcF = 32'h0; #1 check("r1_pc0", instrF, 32'hAAAA0001);

        // Reset mid-LOAD after two words.
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        repeat (DEPTH) cyc();
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1; load_data = 32'h0BAD0000 + 32'(i);
            cyc();
        end
        load_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ar_ready", 32'(load_ready), 32'd0);
        check("ar_core", 32'(core_rst_n), 32'd0);
        check("ar_instr", instrF, NOP);
        cyc();
        rst_n = 1'b1;
        repeat (DEPTH) cyc();
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        check("ar_idle_start", 32'(load_ready), 32'd1);
        load_valid = 1'b1; load_data = 32'h00100073; load_last = 1'b1;
        cyc();
        load_valid = 1'b0; load_last = 1'b0;
        pcF = 32'h4; #1 check("ar_no_stale", instrF, 32'h00000013);

        // Start pulse during post-reset clear is latched.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        repeat (10) cyc();
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        repeat (DEPTH - 12) cyc();
        check("pend_wait", 32'(load_ready), 32'd0);
        cyc();
        check("pend_load", 32'(load_ready), 32'd1);
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
